// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: grid size, play-flow state encoding, cell indexing.
`define GOL_CELL_IDX(x, y) ((y) * gol_pkg::MAX_X + (x))

package gol_pkg;

    localparam int unsigned MAX_X = 40;
    localparam int unsigned MAX_Y = 30;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        CLEAR = 2'd1,
        PAUSE = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/btn_edge_repeat.sv
// One-cycle move pulse from a button level: fires on the rising edge, then
// after REPEAT_DELAY held cycles, then every REPEAT_RATE cycles while held.
module btn_edge_repeat #(
    parameter int unsigned REPEAT_DELAY = 12500000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic en,
    output logic move_c
);

    localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    logic             btn_q;
    logic             repeating_q, repeating_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             limit_hit;

    // cnt holds the number of cycles held since the last move
    always_comb begin
        move_c      = 1'b0;
        cnt_d       = cnt_q;
        repeating_d = repeating_q;
        limit_hit   = repeating_q ? (cnt_q == CNT_W'(REPEAT_RATE))
                                  : (cnt_q == CNT_W'(REPEAT_DELAY));
        if (btn && !btn_q) begin
            move_c      = en;
            cnt_d       = CNT_W'(1);
            repeating_d = 1'b0;
        end else if (btn) begin
            if (limit_hit) begin
                move_c      = en;
                cnt_d       = CNT_W'(1);
                repeating_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d       = '0;
            repeating_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q       <= 1'b0;
            repeating_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            btn_q       <= btn;
            repeating_q <= repeating_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/gol_play_ctrl.sv
// Game-flow controller: title/clear/edit-run sequencing, cursor, draw strobes
// and generation ticks for the Game-of-Life cell-array datapath.
module gol_play_ctrl #(
    parameter int unsigned MAX_X           = gol_pkg::MAX_X,
    parameter int unsigned MAX_Y           = gol_pkg::MAX_Y,
    parameter int unsigned GEN_PERIOD_BASE = 25000000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000,
    parameter int unsigned N_PATTERNS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_draw,
    input  logic        btn_pattern,
    input  logic [1:0]  speed,
    output logic        start_screen,
    output logic        freeze,
    output logic        draw,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic [2:0]  pattern_sel,
    output logic [15:0] gen_count,
    output logic        running
);

    import gol_pkg::*;

    localparam int unsigned CNT_W   = $clog2(GEN_PERIOD_BASE + 1);
    localparam int unsigned B_START = 0;
    localparam int unsigned B_RUN   = 1;
    localparam int unsigned B_STEP  = 2;
    localparam int unsigned B_DRAW  = 3;
    localparam int unsigned B_PAT   = 4;

    state_t           state_q, state_d;
    logic [4:0]       btn_now, btn_q, rise;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
    logic             pend_q, pend_d;
    logic             active, fire, wrap;
    logic             mv_up, mv_down, mv_left, mv_right;
    logic             start_screen_d, freeze_d, draw_d, running_d;
    logic [7:0]       cur_x_d, cur_y_d;
    logic [2:0]       pat_d;
    logic [15:0]      gen_d;

    assign btn_now   = {btn_pattern, btn_draw, btn_step, btn_run, btn_start};
    assign rise      = btn_now & ~btn_q;
    assign active    = (state_q == PAUSE) || (state_q == RUN);
    assign period_m1 = CNT_W'(GEN_PERIOD_BASE >> speed) - CNT_W'(1);

    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
        .clk(clk), .rst(rst), .btn(btn_up), .en(active), .move_c(mv_up));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down (
        .clk(clk), .rst(rst), .btn(btn_down), .en(active), .move_c(mv_down));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_left (
        .clk(clk), .rst(rst), .btn(btn_left), .en(active), .move_c(mv_left));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_right (
        .clk(clk), .rst(rst), .btn(btn_right), .en(active), .move_c(mv_right));

    // Next state, tick scheduling and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pend_d  = pend_q;
        fire    = 1'b0;
        wrap    = 1'b0;
        draw_d  = 1'b0;
        cur_x_d = cursor_x;
        cur_y_d = cursor_y;
        pat_d   = pattern_sel;
        gen_d   = gen_count;

        unique case (state_q)
            TITLE: if (rise[B_START]) state_d = CLEAR;
            CLEAR: state_d = PAUSE;
            PAUSE: if (rise[B_RUN]) state_d = RUN;
            RUN: begin
                if (rise[B_RUN]) begin
                    state_d = PAUSE;
                end else if (speed != speed_q) begin
                    cnt_d = '0;
                end else if (cnt_q == period_m1) begin
                    wrap = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (active) begin
            // a draw strobe owns the cycle; the tick stays pending for the next one
            draw_d = rise[B_DRAW];
            fire   = pend_q && !rise[B_DRAW];
            pend_d = (pend_q && !fire) || wrap || ((state_q == PAUSE) && rise[B_STEP]);
            if ((state_q == RUN) && rise[B_RUN]) begin
                fire   = 1'b0;
                pend_d = 1'b0;
            end
            gen_d = gen_count + 16'(fire);

            if (mv_right && !mv_left)
                cur_x_d = (cursor_x == 8'(MAX_X - 1)) ? 8'd0 : cursor_x + 8'd1;
            else if (mv_left && !mv_right)
                cur_x_d = (cursor_x == 8'd0) ? 8'(MAX_X - 1) : cursor_x - 8'd1;
            if (mv_down && !mv_up)
                cur_y_d = (cursor_y == 8'(MAX_Y - 1)) ? 8'd0 : cursor_y + 8'd1;
            else if (mv_up && !mv_down)
                cur_y_d = (cursor_y == 8'd0) ? 8'(MAX_Y - 1) : cursor_y - 8'd1;

            if (rise[B_PAT])
                pat_d = (pattern_sel == 3'(N_PATTERNS - 1)) ? 3'd0 : pattern_sel + 3'd1;
        end

        freeze_d       = !fire;
        start_screen_d = (state_d == TITLE);
        running_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= TITLE;
            btn_q        <= '0;
            speed_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            start_screen <= 1'b1;
            freeze       <= 1'b1;
            draw         <= 1'b0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            pattern_sel  <= '0;
            gen_count    <= '0;
            running      <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn_now;
            speed_q      <= speed;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            start_screen <= start_screen_d;
            freeze       <= freeze_d;
            draw         <= draw_d;
            cursor_x     <= cur_x_d;
            cursor_y     <= cur_y_d;
            pattern_sel  <= pat_d;
            gen_count    <= gen_d;
            running      <= running_d;
        end
    end

endmodule

// File: tb/tb_gol_play_ctrl.sv
// Scoreboard bench for gol_play_ctrl: stimulus pushes expected cursor/pattern/draw
// events, a negedge monitor pops and compares them; directed checks cover timing.
module tb_gol_play_ctrl;

    localparam int unsigned MX  = 40;
    localparam int unsigned MY  = 30;
    localparam int unsigned GPB = 8;
    localparam int unsigned RD  = 4;
    localparam int unsigned RR  = 2;
    localparam int unsigned NP  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  btns;   // up down left right start run step draw pattern
    logic [1:0]  speed;
    logic        start_screen, freeze, draw, running;
    logic [7:0]  cursor_x, cursor_y;
    logic [2:0]  pattern_sel;
    logic [15:0] gen_count;

    always #5 clk = ~clk;

    gol_play_ctrl #(
        .MAX_X(MX), .MAX_Y(MY), .GEN_PERIOD_BASE(GPB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .N_PATTERNS(NP)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]),
        .btn_start(btns[4]), .btn_run(btns[5]), .btn_step(btns[6]), .btn_draw(btns[7]),
        .btn_pattern(btns[8]), .speed(speed),
        .start_screen(start_screen), .freeze(freeze), .draw(draw),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .pattern_sel(pattern_sel),
        .gen_count(gen_count), .running(running)
    );

    int checks = 0;
    int failures = 0;

    // reference model and scoreboard
    int mx = 0, my = 0, mpat = 0;
    int q_cur[$];
    int q_pat[$];
    int exp_draws = 0, draws_seen = 0;
    int exp_steps = 0, pulse_cnt = 0;
    int exp_gen = 0;
    bit mon_en = 1'b0;
    logic [7:0] last_x, last_y;
    logic [2:0] last_pat;
    logic last_draw, last_freeze;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        failures++;
        $display("FAIL %s", msg);
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (mon_en) begin
            if (cursor_x != last_x || cursor_y != last_y) begin
                if (q_cur.size() == 0) fail_now($sformatf("cursor_move unexpected to (%0d,%0d)", cursor_x, cursor_y));
                else begin
                    e = q_cur.pop_front();
                    chk("cursor_pos", {cursor_x, cursor_y}, e);
                end
            end
            if (pattern_sel != last_pat) begin
                if (q_pat.size() == 0) fail_now($sformatf("pattern_sel unexpected change to %0d", pattern_sel));
                else begin
                    e = q_pat.pop_front();
                    chk("pattern_sel", pattern_sel, e);
                end
            end
            if (draw) begin
                draws_seen++;
                chk("draw_forces_freeze", freeze, 1);
                chk("draw_one_cycle", last_draw, 0);
            end
            if (!freeze) begin
                pulse_cnt++;
                exp_gen = (exp_gen + 1) & 16'hFFFF;
                chk("freeze_one_cycle", last_freeze, 1);
                chk("gen_on_tick", gen_count, exp_gen);
            end else if (gen_count != 16'(exp_gen)) begin
                chk("gen_stable", gen_count, exp_gen);
            end
            last_x      = cursor_x;
            last_y      = cursor_y;
            last_pat    = pattern_sel;
            last_draw   = draw;
            last_freeze = freeze;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int n_moves(input int h);
        if (h <= 0) return 0;
        if (h - 1 < int'(RD)) return 1;
        return 2 + (h - 1 - int'(RD)) / int'(RR);
    endfunction

    task automatic hold2(input int a, input int b, input int n);
        btns[a] = 1'b1;
        btns[b] = 1'b1;
        cycles(n);
        btns[a] = 1'b0;
        btns[b] = 1'b0;
        cycles(1);
    endtask

    task automatic hold(input int a, input int n);
        hold2(a, a, n);
    endtask

    task automatic move(input int dir, input int h);
        for (int k = 0; k < n_moves(h); k++) begin
            case (dir)
                0: my = (my + int'(MY) - 1) % int'(MY);
                1: my = (my + 1) % int'(MY);
                2: mx = (mx + int'(MX) - 1) % int'(MX);
                default: mx = (mx + 1) % int'(MX);
            endcase
            q_cur.push_back(mx * 256 + my);
        end
        hold(dir, h);
    endtask

    task automatic press_pattern();
        mpat = (mpat + 1) % int'(NP);
        q_pat.push_back(mpat);
        hold(8, 1);
    endtask

    task automatic action(input int a, input bit in_pause);
        int h;
        h = $urandom_range(1, 10);
        case (a)
            0, 1, 2, 3: move(a, h);
            4: if ($urandom_range(0, 1) != 0) hold2(0, 1, h); else hold2(2, 3, h);
            5: press_pattern();
            6: begin exp_draws++; hold(7, 1); end
            7: begin if (in_pause) exp_steps++; hold(6, 1); end
            default: begin exp_draws++; if (in_pause) exp_steps++; hold2(6, 7, 1); end
        endcase
        cycles($urandom_range(0, 2));
    endtask

    task automatic wait_pulse(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (freeze !== 1'b0 && n < 40);
        if (freeze !== 1'b0) fail_now($sformatf("%s timeout: no freeze pulse in %0d cycles", name, n));
    endtask

    task automatic drain_check(input string name);
        cycles(6);
        chk({name, "_cursor_queue_empty"}, q_cur.size(), 0);
        chk({name, "_pattern_queue_empty"}, q_pat.size(), 0);
        chk({name, "_draw_count"}, draws_seen, exp_draws);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, lows, pc0, s0;
        rst = 1'b0;
        btns = '0;
        speed = 2'd0;
        cycles(2);
        chk("rst_start_screen", start_screen, 1);
        chk("rst_freeze", freeze, 1);
        chk("rst_draw", draw, 0);
        chk("rst_cursor", {cursor_x, cursor_y}, 0);
        chk("rst_pattern", pattern_sel, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_running", running, 0);
        rst = 1'b1;
        cycles(3);

        // title screen ignores everything but start
        hold(3, 2); hold(8, 1); hold(5, 1); hold(6, 1); hold(7, 1);
        chk("title_start_screen", start_screen, 1);
        chk("title_cursor", {cursor_x, cursor_y}, 0);
        chk("title_pattern", pattern_sel, 0);
        chk("title_running", running, 0);
        chk("title_gen", gen_count, 0);

        btns[4] = 1'b1;
        cycles(1);
        btns[4] = 1'b0;
        chk("clear_start_screen", start_screen, 0);
        chk("clear_freeze", freeze, 1);
        chk("clear_running", running, 0);
        last_x = '0; last_y = '0; last_pat = '0; last_draw = 1'b0; last_freeze = 1'b1;
        exp_gen = 0;
        mon_en = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (!freeze) lows++;
        end
        chk("pause_freeze_held", lows, 0);
        chk("pause_gen_zero", gen_count, 0);
        chk("pause_start_screen", start_screen, 0);

        // cursor wrap and auto-repeat
        move(2, 1);
        chk("left_wrap_x", cursor_x, 39);
        move(0, 1);
        chk("up_wrap_y", cursor_y, 29);
        move(3, 9);
        chk("right_hold9_x", cursor_x, 3);
        hold2(0, 1, 6);
        hold2(2, 3, 6);
        chk("opposite_no_motion", {cursor_x, cursor_y}, 3 * 256 + 29);

        // step and pattern
        pc0 = pulse_cnt;
        exp_steps++;
        hold(6, 1);
        cycles(3);
        chk("step_single_pulse", pulse_cnt - pc0, 1);
        for (int i = 0; i < 9; i++) press_pattern();
        chk("pattern_nine_presses", pattern_sel, 1);

        // randomized editing while paused
        pc0 = pulse_cnt;
        s0 = exp_steps;
        for (int i = 0; i < 30; i++) action($urandom_range(0, 8), 1'b1);
        drain_check("pause_rand");
        chk("pause_rand_step_pulses", pulse_cnt - pc0, exp_steps - s0);

        // run at speed 0 then speed 2
        hold(5, 1);
        chk("run_running", running, 1);
        wait_pulse("run_first", n);
        for (int i = 0; i < 3; i++) begin
            wait_pulse("run_s0", n);
            chk("period_speed0", n, GPB);
        end
        speed = 2'd2;
        wait_pulse("sync_s2a", n);
        wait_pulse("sync_s2b", n);
        for (int i = 0; i < 3; i++) begin
            wait_pulse("run_s2", n);
            chk("period_speed2", n, GPB >> 2);
        end

        // draw colliding with a due tick
        speed = 2'd0;
        wait_pulse("sync_s0a", n);
        wait_pulse("sync_s0b", n);
        cycles(GPB - 1);
        btns[7] = 1'b1;
        exp_draws++;
        cycles(1);
        btns[7] = 1'b0;
        chk("collide_draw", draw, 1);
        chk("collide_freeze_held", freeze, 1);
        cycles(1);
        chk("deferred_tick_freeze", freeze, 0);
        wait_pulse("post_defer", n);
        chk("post_defer_interval", n, GPB - 1);

        // randomized editing while running
        speed = 2'($urandom_range(0, 1));
        for (int i = 0; i < 20; i++) action($urandom_range(0, 8), 1'b0);
        drain_check("run_rand");

        // asynchronous reset with a tick pending
        move(3, 1);
        speed = 2'd0;
        wait_pulse("sync_rst_a", n);
        wait_pulse("sync_rst_b", n);
        cycles(GPB - 1);
        mon_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_freeze", freeze, 1);
        chk("async_rst_start_screen", start_screen, 1);
        chk("async_rst_cursor", {cursor_x, cursor_y}, 0);
        chk("async_rst_gen", gen_count, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_pattern", pattern_sel, 0);
        #1 rst = 1'b1;
        cycles(3);
        hold(5, 1);
        hold(3, 1);
        cycles(3);
        chk("post_rst_title", start_screen, 1);
        chk("post_rst_running", running, 0);
        chk("post_rst_cursor", {cursor_x, cursor_y}, 0);
        chk("post_rst_freeze", freeze, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
